viterbi_traceback: RTL and testbench
====================================

# viterbi_traceback

Traceback stage of the K=3, 4-state hard-decision Viterbi decoder, directly downstream of the add-compare-select unit. Each accepted cycle stores the four 2-bit survivor pointers from the ACS into a register-based survivor memory. Once a frame of `TB_DEPTH` trellis steps is stored, the block walks the pointers backwards from the ACS-selected best final state. It then emits the decoded bits serially in original (oldest-first) order.

## Interface
- `TB_DEPTH`, 8: trellis steps per frame; legal range 4..32.
- `CNT_W`, `$clog2(TB_DEPTH)`: width of step/output counters.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: synchronous, active-low reset.
- `en_tb` input 1: ACS step valid; one trellis step per asserted cycle.
- `i_prev_st_00` input 2: survivor (previous state) for state 00.
- `i_prev_st_10` input 2: survivor for state 10.
- `i_prev_st_01` input 2: survivor for state 01.
- `i_prev_st_11` input 2: survivor for state 11.
- `i_slt_node` input 2: ACS best-metric state; sampled only with the last step of a frame.
- `o_ready` output 1: high while in FILL; a step is accepted only when `en_tb & o_ready`.
- `o_bit` output 1: decoded bit, meaningful when `o_bit_valid`.
- `o_bit_valid` output 1: decoded bit strobe.
- `o_frame_end` output 1: high with the last valid bit of a frame.

## Operation
- Trellis convention: a transition from previous state p with input u gives s = {u, p[1]}. The decoded bit for the step ending in state s is s[1].
- Memory: `TB_DEPTH` × 4 × 2-bit flops, `mem[step][state]`. Writes use `step_cnt`; reads are combinational by index.
- FSM states:
  - **FILL**: `o_ready`=1. On `en_tb`, write all four pointers to `mem[step_cnt]` and increment `step_cnt`. `en_tb` low holds everything, so gaps are allowed.
    - On the write where `step_cnt`=`TB_DEPTH`-1: capture `i_slt_node` into `cur_st`, set `tb_idx`=`TB_DEPTH`-1, clear `step_cnt`, go to TRACE.
  - **TRACE**: `o_ready`=0. Each cycle:
    - `dec[tb_idx] <= cur_st[1]`.
    - `cur_st <= mem[tb_idx][cur_st]`.
    - Decrement `tb_idx`.
    - After the cycle with `tb_idx`=0, clear `out_cnt` and go to OUT.
  - **OUT**: `o_ready`=0.
    - `o_bit = dec[out_cnt]`, `o_bit_valid = 1`, `o_frame_end = (out_cnt == TB_DEPTH-1)`.
    - `out_cnt` increments each cycle. After the cycle with `out_cnt`=`TB_DEPTH`-1, go to FILL.
- Outputs are decoded from registered state only; there is no combinational path from inputs to outputs.
- `en_tb` outside FILL is ignored: no write, no error, and the data is lost. The upstream stage must stall on `!o_ready`.
- Survivor consistency (p[1]==s[0]) is not checked. Pointers are followed verbatim.
- Counters never wrap mid-state. Each counter is reset explicitly at its state exit.

## Timing
- Reset (`rst`=0 at a rising edge) gives: FILL, `step_cnt`/`tb_idx`/`out_cnt`/`cur_st`/`dec` = 0. Outputs: `o_ready`=1, `o_bit`=0, `o_bit_valid`=0, `o_frame_end`=0. Memory contents are don't-care.
- Reset mid-frame (FILL, TRACE or OUT) aborts the frame. The partial frame is discarded, and no further `o_bit_valid` occurs until a complete new frame is filled.
- Let E be the edge that accepts the last step of a frame:
  - TRACE occupies edges E+1..E+`TB_DEPTH`.
  - `o_bit_valid` is high for the `TB_DEPTH` cycles following edge E+`TB_DEPTH`.
  - `o_ready` rises after edge E+2·`TB_DEPTH`.
- Latency from the last accepted step to the first valid bit is `TB_DEPTH` cycles.
- Frame period with continuous `en_tb` is 3·`TB_DEPTH` cycles.
- If `en_tb` is high on the cycle `o_ready` rises, that step is accepted as step 0 of the next frame.

## Test plan
- **Reset:**
  - Stimulus: hold `rst`=0 for 2 cycles with random inputs.
  - Required: `o_ready`=1, `o_bit_valid`=0, `o_bit`=0, `o_frame_end`=0.
- **All-zero path:**
  - Stimulus: `TB_DEPTH`=8; 8 steps with all pointers 00 and `i_slt_node`=00.
  - Required: 8 valid bits all 0; `o_frame_end` on the 8th bit; first valid bit exactly 8 cycles after the last write.
- **Known sequence 1,0,1,1,0,0,1,0:**
  - Stimulus: true states 10,01,10,11,01,00,10,01. At step k, the pointer for the true state equals the true state of step k-1 (00 for k=0); all other pointers are 00. `i_slt_node`=01.
  - Required: `o_bit` = 1,0,1,1,0,0,1,0 in order.
- **Gapped input:**
  - Stimulus: same as the known-sequence test, with `en_tb` low for 3 cycles between steps 2 and 3 and for 1 cycle between steps 5 and 6.
  - Required: identical output; timing is measured from the last accepted step.
- **Back-pressure and back-to-back frames:**
  - Stimulus: hold `en_tb`=1 continuously with changing pointer data.
  - Required: `o_ready` low during TRACE/OUT; steps presented then are not stored; the second frame decodes only its accepted steps; frame period is 24 cycles.
- **Reset mid-TRACE:**
  - Stimulus: assert `rst` at TRACE cycle 3, then send a full all-zero frame.
  - Required: no `o_bit_valid` before the new frame completes; the new frame outputs 8 zeros.

Source files
------------

// File: rtl/viterbi_traceback.sv
// Traceback stage of a K=3, 4-state hard-decision Viterbi decoder.
// Stores one frame of survivor pointers, walks them back from the ACS-selected
// best final state, then emits the decoded bits oldest-first.
module viterbi_traceback #(
    parameter int unsigned TB_DEPTH = 8,
    parameter int unsigned CNT_W    = $clog2(TB_DEPTH)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en_tb,
    input  logic [1:0] i_prev_st_00,
    input  logic [1:0] i_prev_st_10,
    input  logic [1:0] i_prev_st_01,
    input  logic [1:0] i_prev_st_11,
    input  logic [1:0] i_slt_node,
    output logic       o_ready,
    output logic       o_bit,
    output logic       o_bit_valid,
    output logic       o_frame_end
);

    localparam logic [CNT_W-1:0] LastIdx = CNT_W'(TB_DEPTH - 1);

    typedef enum logic [1:0] {
        StFill,
        StTrace,
        StOut
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    step_cnt_q, step_cnt_d;
    logic [CNT_W-1:0]    tb_idx_q, tb_idx_d;
    logic [CNT_W-1:0]    out_cnt_q, out_cnt_d;
    logic [1:0]          cur_st_q, cur_st_d;
    logic [TB_DEPTH-1:0] dec_q, dec_d;

    // Survivor memory, indexed [step][state value]; no reset, contents are
    // always fully rewritten before a traceback reads them.
    logic [1:0] mem_q [TB_DEPTH][4];
    logic [1:0] mem_d [TB_DEPTH][4];

    // Next-state logic for the FILL / TRACE / OUT sequencer and survivor memory.
    always_comb begin
        state_d    = state_q;
        step_cnt_d = step_cnt_q;
        tb_idx_d   = tb_idx_q;
        out_cnt_d  = out_cnt_q;
        cur_st_d   = cur_st_q;
        dec_d      = dec_q;
        mem_d      = mem_q;

        unique case (state_q)
            StFill: begin
                if (en_tb) begin
                    mem_d[step_cnt_q][0] = i_prev_st_00;
                    mem_d[step_cnt_q][1] = i_prev_st_01;
                    mem_d[step_cnt_q][2] = i_prev_st_10;
                    mem_d[step_cnt_q][3] = i_prev_st_11;
                    if (step_cnt_q == LastIdx) begin
                        // Best final state is only meaningful with the last step.
                        cur_st_d   = i_slt_node;
                        tb_idx_d   = LastIdx;
                        step_cnt_d = '0;
                        state_d    = StTrace;
                    end else begin
                        step_cnt_d = step_cnt_q + 1'b1;
                    end
                end
            end
            StTrace: begin
                // Decoded bit for the step ending in state s is s[1].
                dec_d[tb_idx_q] = cur_st_q[1];
                cur_st_d        = mem_q[tb_idx_q][cur_st_q];
                if (tb_idx_q == '0) begin
                    out_cnt_d = '0;
                    state_d   = StOut;
                end else begin
                    tb_idx_d = tb_idx_q - 1'b1;
                end
            end
            StOut: begin
                if (out_cnt_q == LastIdx) begin
                    out_cnt_d = '0;
                    state_d   = StFill;
                end else begin
                    out_cnt_d = out_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = StFill;
            end
        endcase
    end

    // Control and decode registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= StFill;
            step_cnt_q <= '0;
            tb_idx_q   <= '0;
            out_cnt_q  <= '0;
            cur_st_q   <= '0;
            dec_q      <= '0;
        end else begin
            state_q    <= state_d;
            step_cnt_q <= step_cnt_d;
            tb_idx_q   <= tb_idx_d;
            out_cnt_q  <= out_cnt_d;
            cur_st_q   <= cur_st_d;
            dec_q      <= dec_d;
        end
    end

    // Survivor memory register.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // Outputs decoded purely from registered state.
    always_comb begin
        o_ready     = (state_q == StFill);
        o_bit_valid = (state_q == StOut);
        o_bit       = o_bit_valid & dec_q[out_cnt_q];
        o_frame_end = o_bit_valid && (out_cnt_q == LastIdx);
    end

endmodule

// File: tb/tb_viterbi_traceback.sv
// Directed bench for viterbi_traceback: frame tables of true trellis states with
// hand-computed decoded bits, plus reset, gap, back-pressure and abort sequences.
module tb_viterbi_traceback;

    localparam int unsigned D = 8;

    logic       clk;
    logic       rst;
    logic       en_tb;
    logic [1:0] p00, p10, p01, p11, slt;
    logic       o_ready, o_bit, o_bit_valid, o_frame_end;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [1:0] st;       // true state at this step
        logic       bit_exp;  // decoded bit expected for this step
    } vec_t;

    vec_t seq [3][D];

    viterbi_traceback #(.TB_DEPTH(D)) dut (
        .clk          (clk),
        .rst          (rst),
        .en_tb        (en_tb),
        .i_prev_st_00 (p00),
        .i_prev_st_10 (p10),
        .i_prev_st_01 (p01),
        .i_prev_st_11 (p11),
        .i_slt_node   (slt),
        .o_ready      (o_ready),
        .o_bit        (o_bit),
        .o_bit_valid  (o_bit_valid),
        .o_frame_end  (o_frame_end)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Inputs while the block is not expected to accept anything.
    task automatic junk(input logic hold);
        en_tb = hold;
        p00   = 2'($urandom);
        p10   = 2'($urandom);
        p01   = 2'($urandom);
        p11   = 2'($urandom);
        slt   = 2'($urandom);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            en_tb = 1'b0;
            @(posedge clk);
            #1;
            chk("ready_in_gap", o_ready, 1'b1);
        end
    endtask

    time last_edge;

    task automatic drive_step(input int f, input int k, input logic hold);
        logic [1:0] prev;
        prev = (k == 0) ? 2'b00 : seq[f][k-1].st;
        {p00, p10, p01, p11} = '0;
        case (seq[f][k].st)
            2'b00: p00 = prev;
            2'b10: p10 = prev;
            2'b01: p01 = prev;
            default: p11 = prev;
        endcase
        slt = (k == D - 1) ? seq[f][D-1].st : 2'($urandom);
        chk($sformatf("ready_step%0d", k), o_ready, 1'b1);
        en_tb = 1'b1;
        @(posedge clk);
        last_edge = $time;
        #1;
        junk(hold);
    endtask

    task automatic send_frame(input int f, input int gap3, input int gap6, input logic hold);
        for (int k = 0; k < D; k++) begin
            if (k == 3 && gap3 > 0) idle(gap3);
            if (k == 6 && gap6 > 0) idle(gap6);
            drive_step(f, k, hold);
        end
    endtask

    // Called at E+1ns, where E is the edge that accepted the last step.
    task automatic expect_frame(input int f, input logic hold);
        for (int c = 0; c < D; c++) begin
            if (c > 0) begin
                @(posedge clk);
                #1;
                junk(hold);
            end
            chk($sformatf("trace_valid_c%0d", c), o_bit_valid, 1'b0);
            chk($sformatf("trace_ready_c%0d", c), o_ready, 1'b0);
        end
        for (int i = 0; i < D; i++) begin
            @(posedge clk);
            #1;
            junk(hold);
            chk($sformatf("out_valid_%0d", i), o_bit_valid, 1'b1);
            chk($sformatf("out_bit_%0d", i), o_bit, seq[f][i].bit_exp);
            chk($sformatf("out_fend_%0d", i), o_frame_end, (i == D - 1));
            chk($sformatf("out_ready_%0d", i), o_ready, 1'b0);
        end
        @(posedge clk);
        #1;
        chk("ready_after_out", o_ready, 1'b1);
        chk("valid_after_out", o_bit_valid, 1'b0);
    endtask

    initial begin
        logic [1:0] st_a [D];
        logic       b_a [D];
        logic [1:0] st_b [D];
        logic       b_b [D];
        time        t1;

        // Frame 0: bits 1,0,1,1,0,0,1,0; s = {u, p[1]} from state 00.
        st_a = '{2'b10, 2'b01, 2'b10, 2'b11, 2'b01, 2'b00, 2'b10, 2'b01};
        b_a  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        // Frame 1: bits 0,1,1,0,1,0,0,1.
        st_b = '{2'b00, 2'b10, 2'b11, 2'b01, 2'b10, 2'b01, 2'b00, 2'b10};
        b_b  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        for (int k = 0; k < D; k++) begin
            seq[0][k] = '{st: st_a[k], bit_exp: b_a[k]};
            seq[1][k] = '{st: st_b[k], bit_exp: b_b[k]};
            seq[2][k] = '{st: 2'b00, bit_exp: 1'b0};
        end

        // Reset with random inputs.
        rst = 1'b0;
        junk(1'b1);
        repeat (2) begin
            @(posedge clk);
            #1;
            junk(1'(($urandom)));
        end
        chk("rst_ready", o_ready, 1'b1);
        chk("rst_valid", o_bit_valid, 1'b0);
        chk("rst_bit", o_bit, 1'b0);
        chk("rst_fend", o_frame_end, 1'b0);
        rst   = 1'b1;
        en_tb = 1'b0;
        @(posedge clk);
        #1;

        // All-zero path.
        send_frame(2, 0, 0, 1'b0);
        expect_frame(2, 1'b0);

        // Known sequence.
        send_frame(0, 0, 0, 1'b0);
        expect_frame(0, 1'b0);

        // Gapped input.
        send_frame(0, 3, 1, 1'b0);
        expect_frame(0, 1'b0);

        // Continuous en_tb with back-pressure and back-to-back frames.
        send_frame(1, 0, 0, 1'b1);
        t1 = last_edge;
        expect_frame(1, 1'b1);
        send_frame(0, 0, 0, 1'b1);
        chk_int("frame_period", int'((last_edge - t1) / 10), 3 * D);
        expect_frame(0, 1'b0);

        // Reset at TRACE cycle 3 aborts the frame.
        send_frame(0, 0, 0, 1'b0);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        chk("abort_ready", o_ready, 1'b1);
        for (int c = 0; c < 3 * D; c++) begin
            @(posedge clk);
            #1;
            chk($sformatf("abort_valid_%0d", c), o_bit_valid, 1'b0);
        end
        send_frame(2, 0, 0, 1'b0);
        expect_frame(2, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
